// File: rtl/scmp_trace_pkg.sv
// Shared types for the SC/MP bus tracer: ctl byte layout, capture FSM states
// and the {dat, ctl} sample record stored in the trace FIFO.
package scmp_trace_pkg;

  localparam int CTL_RST = 6;
  localparam int CTL_SI  = 5;
  localparam int CTL_SB  = 4;
  localparam int CTL_SA  = 3;
  localparam int CTL_GAP = 2;
  localparam int CTL_ADS = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [7:0] dat;
    logic [7:0] ctl;
  } trace_sample_t;

  // Bits 7 and 0 are fixed markers so a decoder can resync on the ctl byte.
  function automatic logic [7:0] pack_ctl(
    input logic cpu_rst_n,
    input logic s_i,
    input logic sb,
    input logic sa,
    input logic gap,
    input logic ads_n
  );
    logic [7:0] c;
    c          = 8'h81;
    c[CTL_RST] = cpu_rst_n;
    c[CTL_SI]  = s_i;
    c[CTL_SB]  = sb;
    c[CTL_SA]  = sa;
    c[CTL_GAP] = gap;
    c[CTL_ADS] = ads_n;
    return c;
  endfunction

endpackage

// File: rtl/scmp_trace_fifo.sv
// Synchronous trace FIFO with wrap-bit pointers; read data is the registered
// head entry, so a write is visible on the output right after its edge.
module scmp_trace_fifo #(
  parameter int DEPTH_LOG2 = 9,
  parameter int WIDTH      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [WIDTH-1:0]    wdata_i,
  output logic [WIDTH-1:0]    rdata_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [DEPTH_LOG2:0] level_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] PTR_ONE = 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0] rd_ptr_q, rd_ptr_d;
  logic                push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                   (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];

  // A push into a full FIFO is legal when the head leaves at the same edge.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= wdata_i;
  end

endmodule

// File: rtl/scmp_bus_trace.sv
// SC/MP external-bus tracer: samples the bus every clk, queues {dat, ctl}
// pairs and streams them out one byte at a time in the dump byte format.
module scmp_bus_trace
  import scmp_trace_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9,
  parameter int POST_HALT  = 800,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                clr_ovf,
  input  logic                cpu_rst_n,
  input  logic                ads_n,
  input  logic                rd_n,
  input  logic                wr_n,
  input  logic [7:0]          d_i,
  input  logic [7:0]          d_o,
  input  logic                sa,
  input  logic                sb,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done,
  output logic                halt_seen,
  output logic                overflow,
  output logic [CNT_W-1:0]    drop_count,
  output logic [DEPTH_LOG2:0] level,
  output trace_state_t        dbg_state_o,
  output logic [7:0]          dbg_status_o
);

  // Stream handshake: a byte moves on every edge where out_valid && out_ready;
  // while out_ready is low, out_valid and out_data hold their values.

  localparam int PC_W = (POST_HALT < 2) ? 1 : $clog2(POST_HALT + 1);
  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [PC_W-1:0]  PC_LOAD = PC_W'(POST_HALT);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  trace_state_t  state_q, state_d;
  logic [PC_W-1:0] post_cnt_q, post_cnt_d;
  logic [7:0]    status_q;
  logic          phase_q;
  logic          halt_q;
  logic          ovf_q;
  logic [CNT_W-1:0] drop_q;
  logic          gap_q;

  logic          capture, halt_hit, pop, accept, drop;
  logic          fifo_full, fifo_empty;
  logic [7:0]    sample_dat;
  trace_sample_t sample, head;

  assign capture  = arm && ((state_q == RUN) || (state_q == POST));
  assign halt_hit = capture && (state_q == RUN) && !ads_n && d_o[7];
  assign pop      = out_valid && out_ready && phase_q;
  assign accept   = capture && (!fifo_full || pop);
  assign drop     = capture && !accept;

  // Read data wins the bus, then any strobe the core drives, else idle bus.
  always_comb begin
    sample_dat = 8'hFF;
    if (!rd_n)                sample_dat = d_i;
    else if (!ads_n || !wr_n) sample_dat = d_o;
  end

  always_comb begin
    sample     = '0;
    sample.dat = sample_dat;
    sample.ctl = pack_ctl(cpu_rst_n, status_q[5], sb, sa, gap_q, ads_n);
  end

  scmp_trace_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .WIDTH      (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (sample),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (level)
  );

  always_comb begin
    state_d    = state_q;
    post_cnt_d = post_cnt_q;
    if (!arm) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: state_d = RUN;
        RUN: begin
          if (halt_hit) begin
            post_cnt_d = PC_LOAD;
            state_d    = (POST_HALT == 0) ? DONE : POST;
          end
        end
        POST: begin
          // Dropped samples still count toward the post-HALT window.
          post_cnt_d = post_cnt_q - PC_ONE;
          if (post_cnt_q == PC_ONE) state_d = DONE;
        end
        DONE: state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      post_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      post_cnt_q <= post_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status_q <= '0;
      phase_q  <= 1'b0;
      halt_q   <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= '0;
      gap_q    <= 1'b0;
    end else begin
      if (!ads_n)                 status_q <= d_o;
      if (out_valid && out_ready) phase_q  <= ~phase_q;
      if (halt_hit)               halt_q   <= 1'b1;
      if (accept)                 gap_q    <= 1'b0;
      else if (drop)              gap_q    <= 1'b1;
      // Clearing takes priority so a drop on the clear edge is forgotten.
      if (clr_ovf) begin
        ovf_q  <= 1'b0;
        drop_q <= '0;
      end else if (drop) begin
        ovf_q <= 1'b1;
        if (drop_q != '1) drop_q <= drop_q + CNT_ONE;
      end
    end
  end

  assign out_valid    = !fifo_empty;
  assign out_data     = phase_q ? head.ctl : head.dat;
  assign done         = (state_q == DONE);
  assign halt_seen    = halt_q;
  assign overflow     = ovf_q;
  assign drop_count   = drop_q;
  assign dbg_state_o  = state_q;
  assign dbg_status_o = status_q;

endmodule

// File: tb/tb_scmp_bus_trace.sv
// Randomized bench for scmp_bus_trace: a cycle-level behavioural model of the
// tracer feeds an expected byte queue that the accepted output stream is scored against.
module tb_scmp_bus_trace;
  import scmp_trace_pkg::*;

  localparam int DEPTH_LOG2 = 9;
  localparam int POST_HALT  = 800;
  localparam int CNT_W      = 16;
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int DROP_MAX   = (1 << CNT_W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_POST = 2;
  localparam int M_DONE = 3;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic arm = 1'b0, clr_ovf = 1'b0, cpu_rst_n = 1'b1;
  logic ads_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1;
  logic [7:0] d_i = 8'h00, d_o = 8'h00;
  logic sa = 1'b0, sb = 1'b0, out_ready = 1'b0;
  logic [7:0] out_data;
  logic out_valid, done, halt_seen, overflow;
  logic [CNT_W-1:0] drop_count;
  logic [DEPTH_LOG2:0] level;
  trace_state_t dbg_state;
  logic [7:0] dbg_status;

  always #5 clk = ~clk;

  scmp_bus_trace #(
    .DEPTH_LOG2 (DEPTH_LOG2),
    .POST_HALT  (POST_HALT),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .arm          (arm),
    .clr_ovf      (clr_ovf),
    .cpu_rst_n    (cpu_rst_n),
    .ads_n        (ads_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .d_i          (d_i),
    .d_o          (d_o),
    .sa           (sa),
    .sb           (sb),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .done         (done),
    .halt_seen    (halt_seen),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .level        (level),
    .dbg_state_o  (dbg_state),
    .dbg_status_o (dbg_status)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_bytes[$];

  // Reference model: occupancy count, serializer phase, flags.
  int   m_mode, m_left, m_level, m_drops;
  logic m_phase, m_si, m_gap, m_halt, m_ovf;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_left = 0; m_level = 0; m_drops = 0;
    m_phase = 1'b0; m_si = 1'b0; m_gap = 1'b0; m_halt = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
    got_bytes.delete();
  endtask

  // One clock edge of the specified behaviour, using the inputs held across it.
  task automatic model_step();
    logic [7:0] dat, ctl;
    logic cap, pop, hit;
    pop = (m_level > 0) && out_ready && m_phase;
    if ((m_level > 0) && out_ready) m_phase = ~m_phase;
    if (pop) m_level--;
    cap = arm && (m_mode == M_RUN || m_mode == M_POST);
    hit = cap && (m_mode == M_RUN) && !ads_n && d_o[7];
    if (cap) begin
      dat = !rd_n ? d_i : ((!ads_n || !wr_n) ? d_o : 8'hFF);
      ctl = {1'b1, cpu_rst_n, m_si, sb, sa, m_gap, ads_n, 1'b1};
      if (m_level < DEPTH) begin
        m_level++;
        exp_q.push_back(dat);
        exp_q.push_back(ctl);
        m_gap = 1'b0;
      end else begin
        m_gap = 1'b1;
        m_ovf = 1'b1;
        if (m_drops < DROP_MAX) m_drops++;
      end
    end
    if (clr_ovf) begin
      m_ovf = 1'b0;
      m_drops = 0;
    end
    if (!arm) m_mode = M_IDLE;
    else if (m_mode == M_IDLE) m_mode = M_RUN;
    else if (m_mode == M_RUN && hit) begin
      m_halt = 1'b1;
      m_left = POST_HALT;
      m_mode = (POST_HALT == 0) ? M_DONE : M_POST;
    end else if (m_mode == M_POST) begin
      m_left--;
      if (m_left == 0) m_mode = M_DONE;
    end
    if (!ads_n) m_si = d_o[5];
  endtask

  // ---------------- driver ----------------
  task automatic step();
    logic pv, pr;
    logic [7:0] pd;
    logic [8:0] e;
    pv = out_valid; pr = out_ready; pd = out_data;
    @(posedge clk);
    model_step();
    if (pv && pr) begin
      got_bytes.push_back(pd);
      e = (exp_q.size() > 0) ? {1'b0, exp_q.pop_front()} : 9'h100;
      check_eq("stream_byte", 32'(pd), 32'(e));
    end
    #1;
    check_eq("out_valid", 32'(out_valid), 32'(m_level > 0));
    check_eq("level", 32'(level), 32'(m_level));
    check_eq("done", 32'(done), 32'(m_mode == M_DONE));
    check_eq("halt_seen", 32'(halt_seen), 32'(m_halt));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("drop_count", 32'(drop_count), 32'(m_drops));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < budget) begin
      step();
      n++;
    end
    check_eq("drain_empty", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int idx;
    model_reset();
    #1 rst = 1'b1;
    #3;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_level", 32'(level), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_halt_seen", 32'(halt_seen), 32'd0);
    check_eq("rst_overflow", 32'(overflow), 32'd0);
    check_eq("rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Basic stream of read cycles.
    arm = 1'b1; out_ready = 1'b1; rd_n = 1'b0; d_i = 8'h3C;
    run(40);
    check_eq("basic_dat", 32'(got_bytes[0]), 32'h3C);
    check_eq("basic_ctl", 32'(got_bytes[1]), 32'hC3);
    arm = 1'b0;
    drain(200);

    // Status latch: the strobe sample keeps the old s_i, the next one sees it.
    got_bytes.delete();
    arm = 1'b1; rd_n = 1'b1;
    run(1);
    ads_n = 1'b0; d_o = 8'h20;
    run(1);
    ads_n = 1'b1; d_o = 8'h00;
    run(3);
    arm = 1'b0;
    drain(50);
    check_eq("latch_dat", 32'(got_bytes[0]), 32'h20);
    check_eq("latch_ctl", 32'(got_bytes[1]), 32'hC1);
    check_eq("latch_next_si", 32'(got_bytes[3][CTL_SI]), 32'd1);

    // Random bus traffic with random backpressure.
    arm = 1'b1;
    for (int i = 0; i < 600; i++) begin
      ads_n     = ($urandom_range(0, 3) != 0);
      rd_n      = 1'($urandom_range(0, 1));
      wr_n      = 1'($urandom_range(0, 1));
      d_i       = 8'($urandom_range(0, 255));
      d_o       = 8'($urandom_range(0, 127));
      sa        = 1'($urandom_range(0, 1));
      sb        = 1'($urandom_range(0, 1));
      cpu_rst_n = ($urandom_range(0, 7) != 0);
      clr_ovf   = ($urandom_range(0, 31) == 0);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    clr_ovf = 1'b0; ads_n = 1'b1; cpu_rst_n = 1'b1; arm = 1'b0;
    drain(1500);

    // Overflow: fill with the sink stalled, three samples past full.
    arm = 1'b1; out_ready = 1'b0; clr_ovf = 1'b1;
    run(1);
    clr_ovf = 1'b0; rd_n = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      d_i = 8'($urandom_range(0, 255));
      step();
    end
    check_eq("ovf_level", 32'(level), 32'(DEPTH));
    check_eq("ovf_flag", 32'(overflow), 32'd1);
    check_eq("ovf_drops", 32'(drop_count), 32'd3);
    arm = 1'b0;
    drain(1200);
    got_bytes.delete();
    arm = 1'b1;
    run(3);
    arm = 1'b0;
    drain(50);
    check_eq("gap_first", 32'(got_bytes[1][CTL_GAP]), 32'd1);
    check_eq("gap_second", 32'(got_bytes[3][CTL_GAP]), 32'd0);

    // HALT fetch and the post-HALT window.
    got_bytes.delete();
    arm = 1'b1; out_ready = 1'b1; rd_n = 1'b0; d_i = 8'h11;
    run(4);
    rd_n = 1'b1; ads_n = 1'b0; d_o = 8'h80;
    run(1);
    check_eq("halt_flag", 32'(halt_seen), 32'd1);
    rd_n = 1'b0; ads_n = 1'b1; d_o = 8'h00; d_i = 8'h22;
    run(POST_HALT + 20);
    check_eq("halt_done", 32'(done), 32'd1);
    drain(1200);
    idx = -1;
    for (int i = 0; i < got_bytes.size(); i += 2)
      if (idx < 0 && got_bytes[i] == 8'h80) idx = i;
    check_eq("halt_pairs", 32'((got_bytes.size() - idx) / 2), 32'(POST_HALT + 1));
    arm = 1'b0;
    run(1);
    check_eq("disarm_done", 32'(done), 32'd0);
    check_eq("disarm_halt_kept", 32'(halt_seen), 32'd1);

    // Asynchronous reset in the middle of a stalled stream.
    arm = 1'b1; out_ready = 1'b0; rd_n = 1'b0; d_i = 8'h77;
    run(11);
    check_eq("pre_rst_level", 32'(level), 32'd10);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrst_level", 32'(level), 32'd0);
    check_eq("midrst_halt_seen", 32'(halt_seen), 32'd0);
    check_eq("midrst_done", 32'(done), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1; d_i = 8'h5A;
    run(6);
    arm = 1'b0;
    drain(50);
    check_eq("restart_dat", 32'(got_bytes[0]), 32'h5A);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
